// File: rtl/mem_responder.sv
// Serial memory responder: decodes read16/write8/write16 TX messages into a byte RAM and sends read replies on rx_pins.
// Latency: writes commit on the last WDATA edge; a reply starts REPLY_DELAY+1 cycles after the last read address cycle.
// Backpressure: none; both pin bundles are free-running, and an overlapping read is dropped and flagged.
module mem_responder #(
  parameter int NSHIFT      = 2,
  parameter int ADDR_BITS   = 6,
  parameter int REPLY_DELAY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSHIFT-1:0]    tx_pins,
  output logic [NSHIFT-1:0]    rx_pins,
  output logic                 busy,
  output logic                 protocol_error,
  input  logic                 dbg_we,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  input  logic [7:0]           dbg_wdata,
  output logic [7:0]           dbg_rdata
);

  localparam logic [4:0] ADDR_LAST = 5'(16 / NSHIFT - 1);
  localparam logic [4:0] W8_LAST   = 5'(8 / NSHIFT - 1);
  localparam logic [4:0] W16_LAST  = 5'(16 / NSHIFT - 1);
  localparam logic [4:0] RX_LAST   = 5'(16 / NSHIFT - 1);
  localparam logic [3:0] DLY_LOAD  = 4'((REPLY_DELAY > 0) ? REPLY_DELAY - 1 : 0);

  localparam logic [1:0] CMD_RD16 = 2'd0;
  localparam logic [1:0] CMD_WR8  = 2'd1;
  localparam logic [1:0] CMD_WR16 = 2'd2;
  localparam logic [1:0] CMD_RSVD = 2'd3;

  typedef enum logic [1:0] {D_IDLE, D_HEADER, D_ADDR, D_WDATA} dstate_t;
  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_START, R_DATA} rstate_t;

  dstate_t              dstate;
  rstate_t              rstate;
  logic [4:0]           cnt;
  logic [1:0]           cmd;
  logic [15:0]          addr_sr;
  logic [15:0]          wd_sr;
  logic [ADDR_BITS-1:0] waddr;
  logic [3:0]           dcnt;
  logic [4:0]           bcnt;
  logic [15:0]          rsh;

  logic [7:0] mem [2**ADDR_BITS];

  // Incoming chunks enter at the top, so after a full field the first chunk sits at the LSBs.
  logic [15:0]          addr_full;
  logic [15:0]          wd_full;
  logic [ADDR_BITS-1:0] rd_a;
  logic [ADDR_BITS-1:0] rd_a1;
  logic [ADDR_BITS-1:0] waddr_p1;
  logic                 addr_last;
  logic                 wd_last;
  logic                 read_go;
  logic                 wr_lo;
  logic                 wr_hi;
  logic [7:0]           wr_lo_dat;
  logic                 unused_addr_hi;

  assign addr_full      = {tx_pins, addr_sr[15:NSHIFT]};
  assign wd_full        = {tx_pins, wd_sr[15:NSHIFT]};
  assign rd_a           = addr_full[ADDR_BITS-1:0];
  assign rd_a1          = rd_a + {{(ADDR_BITS-1){1'b0}}, 1'b1};
  assign waddr_p1       = waddr + {{(ADDR_BITS-1){1'b0}}, 1'b1};
  assign unused_addr_hi = ^addr_full[15:ADDR_BITS];

  assign addr_last = (dstate == D_ADDR) && (cnt == ADDR_LAST);
  assign wd_last   = (dstate == D_WDATA) && (cnt == ((cmd == CMD_WR8) ? W8_LAST : W16_LAST));
  assign read_go   = addr_last && (cmd == CMD_RD16) && (rstate == R_IDLE);
  assign wr_lo     = wd_last;
  assign wr_hi     = wd_last && (cmd == CMD_WR16);
  // A write8 byte has only filled the upper half of the shifter.
  assign wr_lo_dat = (cmd == CMD_WR8) ? wd_full[15:8] : wd_full[7:0];

  assign busy = (dstate != D_IDLE) || (rstate != R_IDLE);

  // TX decode FSM: start, header, address, optional write data; also owns the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dstate         <= D_IDLE;
      cnt            <= '0;
      cmd            <= '0;
      addr_sr        <= '0;
      wd_sr          <= '0;
      waddr          <= '0;
      protocol_error <= 1'b0;
    end else begin
      case (dstate)
        D_IDLE: begin
          if (tx_pins[0]) dstate <= D_HEADER;
        end
        D_HEADER: begin
          cmd    <= tx_pins[1:0];
          cnt    <= '0;
          dstate <= D_ADDR;
        end
        D_ADDR: begin
          addr_sr <= addr_full;
          cnt     <= cnt + 5'd1;
          if (addr_last) begin
            cnt   <= '0;
            waddr <= rd_a;
            if (cmd == CMD_WR8 || cmd == CMD_WR16) dstate <= D_WDATA;
            else                                   dstate <= D_IDLE;
            // Reserved command, or a read colliding with a reply still in flight.
            if (cmd == CMD_RSVD || (cmd == CMD_RD16 && rstate != R_IDLE))
              protocol_error <= 1'b1;
          end
        end
        D_WDATA: begin
          wd_sr <= wd_full;
          cnt   <= cnt + 5'd1;
          if (wd_last) dstate <= D_IDLE;
        end
        default: dstate <= D_IDLE;
      endcase
    end
  end

  // Reply FSM: snapshot the two bytes, idle for REPLY_DELAY cycles, then start chunk and data chunks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate  <= R_IDLE;
      rx_pins <= '0;
      dcnt    <= '0;
      bcnt    <= '0;
      rsh     <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          rx_pins <= '0;
          if (read_go) begin
            rsh <= {mem[rd_a1], mem[rd_a]};
            if (REPLY_DELAY == 0) begin
              rstate  <= R_START;
              rx_pins <= {{(NSHIFT-1){1'b0}}, 1'b1};
            end else begin
              rstate <= R_DELAY;
              dcnt   <= DLY_LOAD;
            end
          end
        end
        R_DELAY: begin
          if (dcnt == 4'd0) begin
            rstate  <= R_START;
            rx_pins <= {{(NSHIFT-1){1'b0}}, 1'b1};
          end else begin
            dcnt <= dcnt - 4'd1;
          end
        end
        R_START: begin
          rx_pins <= rsh[NSHIFT-1:0];
          rsh     <= rsh >> NSHIFT;
          bcnt    <= '0;
          rstate  <= R_DATA;
        end
        R_DATA: begin
          if (bcnt == RX_LAST) begin
            rx_pins <= '0;
            rstate  <= R_IDLE;
          end else begin
            rx_pins <= rsh[NSHIFT-1:0];
            rsh     <= rsh >> NSHIFT;
            bcnt    <= bcnt + 5'd1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // RAM writes; the protocol write is issued last so it wins a same-byte collision with debug.
  always_ff @(posedge clk) begin
    if (dbg_we) mem[dbg_addr] <= dbg_wdata;
    if (wr_lo)  mem[waddr]    <= wr_lo_dat;
    if (wr_hi)  mem[waddr_p1] <= wd_full[15:8];
  end

  // Registered debug read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbg_rdata <= '0;
    else        dbg_rdata <= mem[dbg_addr];
  end

endmodule
